// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the decode-stage immediate generator:
// format codes, RV base opcodes and the payload record.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 32;

  // Widest-case record for trace/debug consumers; the stage keeps a width-exact copy.
  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    fmt_e                 fmt;
    logic [TAG_W_MAX-1:0] tag;
  } payload_t;

  function automatic logic is_illegal(input fmt_e fmt);
    return fmt == FMT_ILL;
  endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready instruction-in / immediate-out bundle of the immediate generator.
interface imm_gen_stage_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RV instruction -> {sign-extended immediate, format} decoder.
// Kept standalone so execute-stage checks can reuse it.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output fmt_e            o_fmt
);

  logic [31:0] w_imm32;

  always_comb begin
    o_fmt   = FMT_ILL;
    w_imm32 = '0;
    case (i_instr[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
        o_fmt   = FMT_I;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        o_fmt   = FMT_S;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        o_fmt   = FMT_B;
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        o_fmt   = FMT_U;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        o_fmt   = FMT_J;
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
      end
      OP_REG, OP_REG32: o_fmt = FMT_R;
      default: ;
    endcase
  end

  // Every 32-bit immediate above already carries instr[31] in bit 31.
  generate
    if (XLEN > 32) begin : g_ext
      assign o_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_narrow
      assign o_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: one-cycle decode into a main/skid output
// buffer with flush, plus a saturating count of accepted illegal opcodes.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_gen_stage_if.slave   bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_R, tag: '0};

  logic [XLEN-1:0]  w_imm;
  fmt_e             w_fmt;
  entry_t           w_new;
  logic             w_in_xfer;
  logic             w_out_xfer;
  entry_t           r_main;
  entry_t           r_skid;
  logic             r_main_valid;
  logic             r_skid_valid;
  logic [CNT_W-1:0] r_ill_cnt;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr (bus.in_instr),
    .o_imm   (w_imm),
    .o_fmt   (w_fmt)
  );

  assign w_new      = '{imm: w_imm, fmt: w_fmt, tag: bus.in_tag};
  assign w_in_xfer  = bus.in_valid && !r_skid_valid;
  assign w_out_xfer = r_main_valid && bus.out_ready;

  // Skid occupancy alone gates the input, so in_ready never sees out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= ENTRY_RST;
      r_skid       <= ENTRY_RST;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_xfer) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_main       <= w_new;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_xfer) begin
      if (r_main_valid) begin
        r_skid       <= w_new;
        r_skid_valid <= 1'b1;
      end else begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (!flush && w_in_xfer && is_illegal(w_fmt) && (r_ill_cnt != '1)) begin
      r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  assign bus.in_ready    = !r_skid_valid;
  assign bus.out_valid   = r_main_valid;
  assign bus.out_imm     = r_main.imm;
  assign bus.out_fmt     = r_main.fmt;
  assign bus.out_tag     = r_main.tag;
  assign bus.out_illegal = is_illegal(r_main.fmt);
  assign illegal_cnt     = r_ill_cnt;

endmodule
